// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake, frame format configuration and serial line of the UART transmitter.
// The master side is the byte source; the slave side is uart_tx_ctrl.
interface uart_tx_ctrl_if #(
    parameter int unsigned WIDTH     = 21,
    parameter int unsigned DATA_BITS = 8
);
    logic [WIDTH-1:0]     prescaler;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 two_stop;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output prescaler, parity_en, parity_odd, two_stop, tx_data, tx_valid,
        input  tx_ready, tx, busy, frame_done
    );

    modport slave (
        input  prescaler, parity_en, parity_odd, two_stop, tx_data, tx_valid,
        output tx_ready, tx, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first data, optional parity, one or two stop bits.
// Bit timing comes from an internal counter that runs 0..limit, with limit latched when a byte is accepted.
module uart_tx_ctrl #(
    parameter int unsigned WIDTH     = 21,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_tx_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic [2:0]           r_state,    w_state_nxt;
    logic [WIDTH-1:0]     r_cnt,      w_cnt_nxt;
    logic [WIDTH-1:0]     r_limit,    w_limit_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [IDX_W-1:0]     r_idx,      w_idx_nxt;
    logic                 r_par_en,   w_par_en_nxt;
    logic                 r_par_bit,  w_par_bit_nxt;
    logic                 r_two_stop, w_two_stop_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 w_tick;

    // Tick on the last cycle of a bit; comparing for equality lets limit be all-ones without wrap.
    assign w_tick = (r_cnt == r_limit);

    assign bus.tx_ready   = (r_state == S_IDLE);
    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_limit    <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_limit    <= w_limit_nxt;
            r_shift    <= w_shift_nxt;
            r_idx      <= w_idx_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_two_stop <= w_two_stop_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_limit_nxt    = r_limit;
        w_shift_nxt    = r_shift;
        w_idx_nxt      = r_idx;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_two_stop_nxt = r_two_stop;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        if (r_state == S_IDLE) begin
            // Accept: snapshot byte and format so later input changes cannot disturb the frame.
            if (bus.tx_valid) begin
                w_shift_nxt    = bus.tx_data;
                w_limit_nxt    = bus.prescaler;
                w_par_en_nxt   = bus.parity_en;
                w_par_bit_nxt  = (^bus.tx_data) ^ bus.parity_odd;
                w_two_stop_nxt = bus.two_stop;
                w_cnt_nxt      = '0;
                w_state_nxt    = S_START;
                w_tx_nxt       = 1'b0;
                w_busy_nxt     = 1'b1;
            end
        end else if (!w_tick) begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
        end else begin
            w_cnt_nxt = '0;
            case (r_state)
                S_START: begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                    w_idx_nxt   = '0;
                end
                S_DATA: begin
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
                        w_tx_nxt    = r_par_en ? r_par_bit : 1'b1;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end
                S_PARITY: begin
                    w_state_nxt = S_STOP1;
                    w_tx_nxt    = 1'b1;
                end
                S_STOP1: begin
                    if (r_two_stop) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                S_STOP2: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: expected tx waveform built per frame from the framing rules.
// Two instances: the default 21-bit/8-data-bit one, and a 4-bit/5-data-bit one for the all-ones limit.
module tb_uart_tx_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    bit   exp_q[$];

    uart_tx_ctrl_if #(.WIDTH(21), .DATA_BITS(8)) bus_a ();
    uart_tx_ctrl_if #(.WIDTH(4),  .DATA_BITS(5)) bus_b ();

    uart_tx_ctrl #(.WIDTH(21), .DATA_BITS(8)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    uart_tx_ctrl #(.WIDTH(4),  .DATA_BITS(5)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Expected tx level for every cycle of a frame, from the first START cycle to the last stop cycle.
    function automatic void model_frame(input logic [8:0] data, input int nbits, input bit pe,
                                        input bit po, input bit ts, input int presc);
        bit bits[$];
        int ones;
        exp_q.delete();
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bits.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (pe) bits.push_back(((ones % 2) != 0) ^ po);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c <= presc; c++) exp_q.push_back(bits[k]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_a(input int presc, input bit pe, input bit po, input bit ts, input logic [7:0] d);
        bus_a.prescaler  = 21'(presc);
        bus_a.parity_en  = pe;
        bus_a.parity_odd = po;
        bus_a.two_stop   = ts;
        bus_a.tx_data    = d;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_async_a: tx/busy/done/ready got %b want 1001",
                     {bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus_b.tx, bus_b.busy, bus_b.frame_done, bus_b.tx_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_b: tx/busy/done/ready got %b want 1001",
                     {bus_b.tx, bus_b.busy, bus_b.frame_done, bus_b.tx_ready});
        end
    endtask

    task automatic test_basic();
        cfg_a(3, 1'b0, 1'b0, 1'b0, 8'h55);
        model_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 3);
        bus_a.tx_valid = 1'b1;
        tick();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1 || bus_a.frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL basic cyc%0d: tx/busy/done got %b%b%b want %b10",
                         i, bus_a.tx, bus_a.busy, bus_a.frame_done, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready} !== 4'b1011) begin
            n_err++;
            $display("FAIL basic_end: tx/busy/done/ready got %b want 1011",
                     {bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready});
        end
        tick();
        n_cmp++;
        if (bus_a.frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse: frame_done got %b want 0", bus_a.frame_done);
        end
    endtask

    task automatic test_parity();
        for (int po = 0; po < 2; po++) begin
            cfg_a(0, 1'b1, 1'(po), 1'b1, 8'hA3);
            model_frame(9'h0A3, 8, 1'b1, 1'(po), 1'b1, 0);
            bus_a.tx_valid = 1'b1;
            tick();
            bus_a.tx_valid = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL parity%0d cyc%0d: tx/busy got %b%b want %b1",
                             po, i, bus_a.tx, bus_a.busy, exp_q[i]);
                end
                if (i == 9) begin
                    n_cmp++;
                    if (bus_a.tx !== 1'(po)) begin
                        n_err++;
                        $display("FAIL parity%0d_bit: tx got %b want %0d", po, bus_a.tx, po);
                    end
                end
                tick();
            end
            n_cmp++;
            if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b101) begin
                n_err++;
                $display("FAIL parity%0d_end: tx/busy/done got %b want 101",
                         po, {bus_a.tx, bus_a.busy, bus_a.frame_done});
            end
            tick();
        end
    endtask

    task automatic test_config_stable();
        cfg_a(5, 1'b0, 1'b0, 1'b0, 8'h0F);
        model_frame(9'h00F, 8, 1'b0, 1'b0, 1'b0, 5);
        bus_a.tx_valid = 1'b1;
        tick();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1) begin
                n_err++;
                $display("FAIL cfg_old cyc%0d: tx/busy got %b%b want %b1", i, bus_a.tx, bus_a.busy, exp_q[i]);
            end
            if (i == 3) begin
                bus_a.prescaler  = 21'd1;
                bus_a.parity_en  = 1'b1;
                bus_a.two_stop   = 1'b1;
                bus_a.parity_odd = 1'b1;
            end
            tick();
        end
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b101) begin
            n_err++;
            $display("FAIL cfg_old_end: tx/busy/done got %b want 101", {bus_a.tx, bus_a.busy, bus_a.frame_done});
        end
        tick();
        bus_a.tx_data = 8'h3C;
        model_frame(9'h03C, 8, 1'b1, 1'b1, 1'b1, 1);
        bus_a.tx_valid = 1'b1;
        tick();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1) begin
                n_err++;
                $display("FAIL cfg_new cyc%0d: tx/busy got %b%b want %b1", i, bus_a.tx, bus_a.busy, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b101) begin
            n_err++;
            $display("FAIL cfg_new_end: tx/busy/done got %b want 101", {bus_a.tx, bus_a.busy, bus_a.frame_done});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cfg_a(1, 1'b0, 1'b0, 1'b0, 8'h01);
        model_frame(9'h001, 8, 1'b0, 1'b0, 1'b0, 1);
        bus_a.tx_valid = 1'b1;
        tick();
        bus_a.tx_data = 8'h80;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_first cyc%0d: tx/busy got %b%b want %b1", i, bus_a.tx, bus_a.busy, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready} !== 4'b1011) begin
            n_err++;
            $display("FAIL b2b_gap: tx/busy/done/ready got %b want 1011",
                     {bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready});
        end
        model_frame(9'h080, 8, 1'b0, 1'b0, 1'b0, 1);
        tick();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1 || bus_a.frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_second cyc%0d: tx/busy/done got %b%b%b want %b10",
                         i, bus_a.tx, bus_a.busy, bus_a.frame_done, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b101) begin
            n_err++;
            $display("FAIL b2b_end: tx/busy/done got %b want 101", {bus_a.tx, bus_a.busy, bus_a.frame_done});
        end
        tick();
    endtask

    task automatic test_abort();
        cfg_a(7, 1'b0, 1'b0, 1'b0, 8'hFF);
        model_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b0, 7);
        bus_a.tx_valid = 1'b1;
        tick();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i]) begin
                n_err++;
                $display("FAIL abort_pre cyc%0d: tx got %b want %b", i, bus_a.tx, exp_q[i]);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL abort_async: tx/busy/done/ready got %b want 1001",
                     {bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready});
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.tx_ready} !== 3'b101) begin
            n_err++;
            $display("FAIL abort_release: tx/busy/ready got %b want 101", {bus_a.tx, bus_a.busy, bus_a.tx_ready});
        end
        bus_a.tx_data = 8'h00;
        model_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 7);
        bus_a.tx_valid = 1'b1;
        tick();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1) begin
                n_err++;
                $display("FAIL abort_fresh cyc%0d: tx/busy got %b%b want %b1", i, bus_a.tx, bus_a.busy, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b101) begin
            n_err++;
            $display("FAIL abort_fresh_end: tx/busy/done got %b want 101", {bus_a.tx, bus_a.busy, bus_a.frame_done});
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        cfg_a(2, 1'b0, 1'b0, 1'b0, 8'h5A);
        model_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 2);
        bus_a.tx_valid = 1'b1;
        tick();
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1 || bus_a.tx_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ignore cyc%0d: tx/busy/ready got %b%b%b want %b10",
                         i, bus_a.tx, bus_a.busy, bus_a.tx_ready, exp_q[i]);
            end
            bus_a.tx_data  = (i == 7) ? 8'h33 : 8'h5A;
            bus_a.tx_valid = (i == 7);
            tick();
        end
        n_cmp++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b101) begin
            n_err++;
            $display("FAIL ignore_end: tx/busy/done got %b want 101", {bus_a.tx, bus_a.busy, bus_a.frame_done});
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready} !== 4'b1001) begin
                n_err++;
                $display("FAIL ignore_idle cyc%0d: tx/busy/done/ready got %b want 1001",
                         i, {bus_a.tx, bus_a.busy, bus_a.frame_done, bus_a.tx_ready});
            end
            tick();
        end
    endtask

    task automatic test_max_limit();
        bus_b.prescaler  = 4'hF;
        bus_b.parity_en  = 1'b1;
        bus_b.parity_odd = 1'b0;
        bus_b.two_stop   = 1'b1;
        bus_b.tx_data    = 5'h13;
        model_frame(9'h013, 5, 1'b1, 1'b0, 1'b1, 15);
        bus_b.tx_valid = 1'b1;
        tick();
        bus_b.tx_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (bus_b.tx !== exp_q[i] || bus_b.busy !== 1'b1 || bus_b.frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL maxlim cyc%0d: tx/busy/done got %b%b%b want %b10",
                         i, bus_b.tx, bus_b.busy, bus_b.frame_done, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if ({bus_b.tx, bus_b.busy, bus_b.frame_done, bus_b.tx_ready} !== 4'b1011) begin
            n_err++;
            $display("FAIL maxlim_end: tx/busy/done/ready got %b want 1011",
                     {bus_b.tx, bus_b.busy, bus_b.frame_done, bus_b.tx_ready});
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         presc;
        bit         pe, po, ts;
        for (int n = 0; n < 10; n++) begin
            d     = 8'($urandom);
            presc = int'($urandom_range(0, 3));
            pe    = 1'($urandom);
            po    = 1'($urandom);
            ts    = 1'($urandom);
            cfg_a(presc, pe, po, ts, d);
            model_frame({1'b0, d}, 8, pe, po, ts, presc);
            bus_a.tx_valid = 1'b1;
            tick();
            bus_a.tx_valid = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (bus_a.tx !== exp_q[i] || bus_a.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand%0d cyc%0d: tx/busy got %b%b want %b1 (data %h presc %0d pe %0d po %0d ts %0d)",
                             n, i, bus_a.tx, bus_a.busy, exp_q[i], d, presc, pe, po, ts);
                end
                tick();
            end
            n_cmp++;
            if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b101) begin
                n_err++;
                $display("FAIL rand%0d_end: tx/busy/done got %b want 101", n, {bus_a.tx, bus_a.busy, bus_a.frame_done});
            end
            repeat (1 + $urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        n_cmp = 0;
        n_err = 0;
        bus_a.prescaler  = '0;
        bus_a.parity_en  = 1'b0;
        bus_a.parity_odd = 1'b0;
        bus_a.two_stop   = 1'b0;
        bus_a.tx_data    = '0;
        bus_a.tx_valid   = 1'b0;
        bus_b.prescaler  = '0;
        bus_b.parity_en  = 1'b0;
        bus_b.parity_odd = 1'b0;
        bus_b.two_stop   = 1'b0;
        bus_b.tx_data    = '0;
        bus_b.tx_valid   = 1'b0;

        test_reset();
        test_basic();
        test_parity();
        test_config_stable();
        test_back_to_back();
        test_abort();
        test_busy_ignore();
        test_max_limit();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
